// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Parametrised serial sequence detector. Bits on A are sampled when En is
//   high. The last cfg_len sampled bits are compared against a programmable
//   pattern. Overlapping and non-overlapping detection are both supported,
//   along with a sticky flag that Ack clears and a saturating hit counter.
//
// Ports
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous active-high reset
//   En       in   A is valid this cycle
//   A        in   serial data bit
//   Clear    in   synchronous clear; also loads Pattern/Len/Overlap
//   Pattern  in   [MAX_W-1:0]; Pattern[Len-1] is the first bit received
//   Len      in   [LW-1:0] pattern length, legal range 1..MAX_W
//   Overlap  in   1 = overlapping matches, 0 = non-overlapping
//   Ack      in   clears Flag
//   Match    out  one-cycle pulse per detection (registered)
//   Flag     out  sticky detection flag
//   Count    out  [CNT_W-1:0] saturating detection count
//   State    out  [1:0] 0 = IDLE, 1 = FILL, 2 = ARMED
module seq_detect_param #(
    parameter int               MAX_W       = 8,
    parameter int               LW          = 4,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(4'b1101),
    parameter logic [LW-1:0]    DEF_LEN     = LW'(4),
    parameter logic             DEF_OVERLAP = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             A,
    input  logic             Clear,
    input  logic [MAX_W-1:0] Pattern,
    input  logic [LW-1:0]    Len,
    input  logic             Overlap,
    input  logic             Ack,
    output logic             Match,
    output logic             Flag,
    output logic [CNT_W-1:0] Count,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

    // Only the newest MAX_W-1 bits are stored. The incoming bit completes the window.
    logic [MAX_W-2:0] hist_q;
    logic [LW-1:0]    fill_q;
    state_e           state_q;
    logic             match_q;
    logic             flag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [MAX_W-1:0] cfg_pat_q;
    logic [LW-1:0]    cfg_len_q;
    logic             cfg_ovl_q;

    logic [MAX_W-1:0] hist_d;
    logic [LW-1:0]    fill_d;
    logic [LW-1:0]    fill_sat;
    logic [MAX_W-1:0] mask;
    logic             len_ok;
    logic             hit;

    always_comb begin
        len_ok = (cfg_len_q != '0) && (cfg_len_q <= LW'(MAX_W));
        hist_d = {hist_q, A};
        // An illegal length never completes, so fill tops out at MAX_W instead.
        fill_sat = len_ok ? cfg_len_q : LW'(MAX_W);
        fill_d   = (fill_q >= fill_sat) ? fill_sat : fill_q + LW'(1);
        mask = '0;
        for (int i = 0; i < MAX_W; i++) mask[i] = (LW'(i) < cfg_len_q);
        hit = En && !Clear && len_ok && (fill_d == cfg_len_q) &&
              (((hist_d ^ cfg_pat_q) & mask) == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= IDLE;
            match_q   <= 1'b0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            cfg_pat_q <= DEF_PATTERN;
            cfg_len_q <= DEF_LEN;
            cfg_ovl_q <= DEF_OVERLAP;
        end else begin
            match_q <= hit;
            // A hit takes priority over Ack. Clear leaves the flag alone.
            flag_q  <= hit | (flag_q & ~Ack);
            if (hit && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (Clear) begin
                hist_q    <= '0;
                fill_q    <= '0;
                state_q   <= IDLE;
                cnt_q     <= '0;
                cfg_pat_q <= Pattern;
                cfg_len_q <= Len;
                cfg_ovl_q <= Overlap;
            end else if (En) begin
                if (hit && !cfg_ovl_q) begin
                    // In non-overlap mode, the next match needs a fully fresh window.
                    hist_q  <= '0;
                    fill_q  <= '0;
                    state_q <= FILL;
                end else begin
                    hist_q  <= hist_d[MAX_W-2:0];
                    fill_q  <= fill_d;
                    state_q <= (len_ok && fill_d == cfg_len_q) ? ARMED : FILL;
                end
            end
        end
    end

    assign Match = match_q;
    assign Flag  = flag_q;
    assign Count = cnt_q;
    assign State = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param. The reference model keeps the received bits
// since the last flush in a queue and compares the tail of that queue with the
// pattern. A second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_param;

    logic       Clock = 1'b0;
    logic       Reset, En, A, Clear, Overlap, Ack;
    logic [7:0] Pattern;
    logic [3:0] Len;
    logic       Match, Flag, Match2, Flag2;
    logic [7:0] Count;
    logic [1:0] State, Count2, State2;

    seq_detect_param u_dut (
        .Clock(Clock), .Reset(Reset), .En(En), .A(A), .Clear(Clear),
        .Pattern(Pattern), .Len(Len), .Overlap(Overlap), .Ack(Ack),
        .Match(Match), .Flag(Flag), .Count(Count), .State(State));

    seq_detect_param #(.CNT_W(2)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .En(En), .A(A), .Clear(Clear),
        .Pattern(Pattern), .Len(Len), .Overlap(Overlap), .Ack(Ack),
        .Match(Match2), .Flag(Flag2), .Count(Count2), .State(State2));

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         mq[$];
    int         mlen, mcnt, mcnt2;
    logic [7:0] mpat;
    bit         movl, mmatch, mflag, mposthit;

    wire [17:0] dut_vec = {Match, Flag, Count, State, Count2, Match2, Flag2, State2};

    function automatic int calc_state();
        bit legal = (mlen >= 1 && mlen <= 8);
        if (mq.size() == 0) return mposthit ? 1 : 0;
        if (!legal) return 1;
        return (mq.size() >= mlen) ? 2 : 1;
    endfunction

    function automatic logic [17:0] exp_vec();
        int s = calc_state();
        return {mmatch, mflag, 8'(mcnt), 2'(s), 2'(mcnt2), mmatch, mflag, 2'(s)};
    endfunction

    task automatic model_reset();
        mq.delete();
        mlen = 4; mpat = 8'b1101; movl = 1'b1;
        mcnt = 0; mcnt2 = 0; mmatch = 0; mflag = 0; mposthit = 0;
    endtask

    task automatic model_edge();
        bit legal = (mlen >= 1 && mlen <= 8);
        bit hit = 0;
        if (Clear) begin
            mq.delete();
            mpat = Pattern; mlen = Len; movl = Overlap;
            mcnt = 0; mcnt2 = 0; mposthit = 0;
        end else if (En) begin
            mq.push_back(A);
            if (mq.size() > 8) void'(mq.pop_front());
            if (legal && mq.size() >= mlen) begin
                hit = 1;
                for (int i = 0; i < mlen; i++)
                    if (mq[mq.size() - mlen + i] != mpat[mlen - 1 - i]) hit = 0;
            end
            if (hit) begin
                if (mcnt < 255) mcnt++;
                if (mcnt2 < 3) mcnt2++;
                if (!movl) begin mq.delete(); mposthit = 1; end
            end
        end
        mmatch = hit;
        if (hit) mflag = 1;
        else if (Ack) mflag = 0;
    endtask

    task automatic step(input bit en, input bit a, input bit clr, input bit ack);
        En = en; A = a; Clear = clr; Ack = ack;
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
        Pattern = p; Len = l; Overlap = o;
        step(0, 0, 1, 0);
    endtask

    task automatic test_reset();
        Reset = 1; En = 0; A = 0; Clear = 0; Ack = 0;
        Pattern = 8'hFF; Len = 4'd2; Overlap = 0;
        model_reset();
        #12;
        total++;
        if (dut_vec !== 18'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", dut_vec);
        end
        Reset = 0;
        @(posedge Clock); #1;
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_default();
        bit bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        bit want[7] = '{0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            step(1, bits[i], 0, 0);
            total++;
            if (dut_vec !== exp_vec() || Match !== want[i]) begin
                bad++; $display("FAIL default bit%0d got=%h want=%h match_req=%0d", i, dut_vec, exp_vec(), want[i]);
            end
        end
        total++;
        if (Count !== 8'd2 || Flag !== 1'b1) begin
            bad++; $display("FAIL default_totals count=%0d flag=%0d want 2/1", Count, Flag);
        end
    endtask

    task automatic test_nonoverlap();
        bit bits[5] = '{1, 0, 1, 0, 1};
        cfg(8'b101, 4'd3, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, bits[i], 0, 0);
            total++;
            if (dut_vec !== exp_vec() || Match !== (i == 2)) begin
                bad++; $display("FAIL nonoverlap bit%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (Count !== 8'd1 || State !== 2'd1) begin
            bad++; $display("FAIL nonoverlap_totals count=%0d state=%0d want 1/1", Count, State);
        end
    endtask

    task automatic test_overlap();
        bit bits[5] = '{1, 0, 1, 0, 1};
        cfg(8'b101, 4'd3, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, bits[i], 0, 0);
            total++;
            if (dut_vec !== exp_vec() || Match !== (i == 2 || i == 4)) begin
                bad++; $display("FAIL overlap bit%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (Count !== 8'd2) begin
            bad++; $display("FAIL overlap_count got=%0d want=2", Count);
        end
    endtask

    task automatic test_en_gaps();
        bit bits[4] = '{1, 1, 0, 1};
        int hits = 0;
        cfg(8'b1101, 4'd4, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, bits[i], 0, 0);
            hits += Match;
            total++;
            if (dut_vec !== exp_vec() || Match !== (i == 3)) begin
                bad++; $display("FAIL en_gaps bit%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            for (int g = 0; g < 3; g++) begin
                step(0, ~bits[i], 0, 0);
                hits += Match;
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++; $display("FAIL en_gaps idle%0d.%0d got=%h want=%h", i, g, dut_vec, exp_vec());
                end
            end
        end
        total++;
        if (hits != 1) begin
            bad++; $display("FAIL en_gaps_single got=%0d want=1", hits);
        end
    endtask

    task automatic test_saturate_ack();
        logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        cfg(8'b1, 4'd1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, i == 4);
            total++;
            if (dut_vec !== exp_vec() || Count2 !== want[i] || Flag !== 1'b1) begin
                bad++; $display("FAIL saturate hit%0d got=%h want=%h count2_req=%0d", i, dut_vec, exp_vec(), want[i]);
            end
        end
        step(1, 0, 0, 1);
        total++;
        if (dut_vec !== exp_vec() || Flag !== 1'b0 || Match !== 1'b0) begin
            bad++; $display("FAIL ack_alone got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        bit bits[4] = '{1, 1, 0, 1};
        cfg(8'b1101, 4'd4, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        #2 Reset = 1; model_reset();
        #1;
        total++;
        if (dut_vec !== 18'd0) begin
            bad++; $display("FAIL reset_mid got=%h want=0", dut_vec);
        end
        #3 Reset = 0;
        #1;
        // These port values must be ignored because Clear is low.
        Pattern = 8'h00; Len = 4'd2; Overlap = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, bits[i], 0, 0);
            total++;
            if (dut_vec !== exp_vec() || Match !== (i == 3)) begin
                bad++; $display("FAIL reset_defaults bit%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
        cfg(8'h00, 4'd0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1'($urandom_range(0, 1)), 0, 0);
            total++;
            if (dut_vec !== exp_vec() || Match !== 1'b0 || State !== 2'd1) begin
                bad++; $display("FAIL len0 bit%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                Pattern = 8'($urandom);
                Len     = 4'($urandom_range(0, 9));
                Overlap = 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 9) == 0) Pattern = 8'($urandom);
                step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0,
                     $urandom_range(0, 7) == 0);
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc%0d len=%0d got=%h want=%h", i, mlen, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_nonoverlap();
        test_overlap();
        test_en_gaps();
        test_saturate_ack();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
